// File: rtl/uart_rx_if.sv
// Serial line plus received-byte output of the UART receiver.
// master drives the line and observes bytes; slave is the receiver itself.
interface uart_rx_if;
   logic       uart_data;
   logic       rx_vld;
   logic [7:0] rx_data;

   modport master (
      output uart_data,
      input  rx_vld,
      input  rx_data
   );

   modport slave (
      input  uart_data,
      output rx_vld,
      output rx_data
   );
endinterface

// File: rtl/uart_rx.sv
// UART receiver: 8N1 framing, N clocks per bit, one mid-bit sample per bit.
// The byte is presented on rx_data together with a one-cycle rx_vld pulse.
module uart_rx #(
   parameter int unsigned N = 8
) (
   input logic      clk,
   input logic      rst_n,
   uart_rx_if.slave bus
);
   localparam int unsigned     CntW    = $clog2(N);
   localparam logic [CntW-1:0] MidCnt  = CntW'(N / 2 - 1);
   localparam logic [CntW-1:0] LastCnt = CntW'(N - 1);

   typedef enum logic [2:0] {
      StIdle,
      StStart,
      StData,
      StStop,
      StWaitIdle
   } state_e;

   state_e          state_q, state_d;
   logic            sync1_q, sync2_q, hist_q;
   logic [CntW-1:0] cnt_q, cnt_d;
   logic [3:0]      idx_q, idx_d;
   logic [7:0]      shift_q, shift_d;
   logic            rx_vld_q, rx_vld_d;
   logic [7:0]      rx_data_q, rx_data_d;
   logic            sample;
   logic [2:0]      data_pos;

   // Reset is active high despite the port name.
   always_ff @(posedge clk) begin
      if (rst_n) begin
         sync1_q   <= 1'b0;
         sync2_q   <= 1'b0;
         hist_q    <= 1'b0;
         state_q   <= StIdle;
         cnt_q     <= '0;
         idx_q     <= '0;
         shift_q   <= '0;
         rx_vld_q  <= 1'b0;
         rx_data_q <= 8'h00;
      end else begin
         sync1_q   <= bus.uart_data;
         sync2_q   <= sync1_q;
         hist_q    <= sync2_q;
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         idx_q     <= idx_d;
         shift_q   <= shift_d;
         rx_vld_q  <= rx_vld_d;
         rx_data_q <= rx_data_d;
      end
   end

   assign sample   = (cnt_q == MidCnt);
   // Bit index 0 is the start bit, so data bit k lives at index k+1.
   assign data_pos = idx_q[2:0] - 3'd1;

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      idx_d     = idx_q;
      shift_d   = shift_q;
      rx_vld_d  = 1'b0;
      rx_data_d = rx_data_q;

      if (state_q inside {StStart, StData, StStop}) begin
         if (cnt_q == LastCnt) begin
            cnt_d = '0;
            idx_d = idx_q + 4'd1;
         end else begin
            cnt_d = cnt_q + 1'b1;
         end
      end

      unique case (state_q)
         StIdle: begin
            if (hist_q && !sync2_q) begin
               state_d = StStart;
               cnt_d   = '0;
               idx_d   = '0;
            end
         end
         StStart: begin
            if (sample) state_d = sync2_q ? StIdle : StData;
         end
         StData: begin
            if (sample) begin
               shift_d[data_pos] = sync2_q;
               if (idx_q == 4'd8) state_d = StStop;
            end
         end
         StStop: begin
            if (sample) begin
               if (sync2_q) begin
                  rx_data_d = shift_q;
                  rx_vld_d  = 1'b1;
                  state_d   = StIdle;
               end else begin
                  state_d = StWaitIdle;
               end
            end
         end
         StWaitIdle: begin
            if (sync2_q) state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   assign bus.rx_vld  = rx_vld_q;
   assign bus.rx_data = rx_data_q;
endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx: frames are generated at the bit level, expected bytes go to a
// scoreboard queue and a negedge monitor checks every rx_vld pulse and rx_data hold.
module tb_uart_rx;
   localparam int unsigned N = 8;

   typedef struct {
      logic [7:0] data;
      int         start;
   } exp_t;

   logic clk;
   logic rst_n;
   int   cyc;
   int   n_checks;
   int   n_fail;
   exp_t exp_q[$];
   logic [7:0] model_data;
   logic prev_vld;

   uart_rx_if bus ();

   uart_rx #(
      .N(N)
   ) dut (
      .clk  (clk),
      .rst_n(rst_n),
      .bus  (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Monitor: every rx_vld must match the oldest expected byte; otherwise rx_data holds.
   always @(negedge clk) begin
      if (rst_n) begin
         model_data = 8'h00;
         prev_vld   = 1'b0;
      end else begin
         if (bus.rx_vld) begin
            check("vld_one_cycle", int'(prev_vld), 0);
            if (exp_q.size() == 0) begin
               check("unexpected_vld", 1, 0);
            end else begin
               exp_t e;
               int   lat;
               e   = exp_q.pop_front();
               lat = cyc - e.start;
               check("rx_data", int'(bus.rx_data), int'(e.data));
               n_checks++;
               if (lat < 78 || lat > 80) begin
                  n_fail++;
                  $display("FAIL latency: got %0d clocks, expected 78..80", lat);
               end
               model_data = e.data;
            end
         end else begin
            check("rx_data_hold", int'(bus.rx_data), int'(model_data));
         end
         prev_vld = bus.rx_vld;
      end
   end

   // All drive tasks start and end just after a rising edge.
   task automatic hold(input logic v, input int cycles);
      bus.uart_data = v;
      repeat (cycles) @(posedge clk);
      #1;
   endtask

   task automatic pulse_reset();
      rst_n         = 1'b1;
      bus.uart_data = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b0;
   endtask

   // abort_bit >= 0 pulses reset halfway through that bit index (0 = start, 9 = stop).
   task automatic send_frame(input logic [7:0] d, input logic stop, input int abort_bit);
      logic [9:0] bits;
      bits = {stop, d, 1'b0};
      if (stop && abort_bit < 0) exp_q.push_back('{data: d, start: cyc + 1});
      for (int b = 0; b < 10; b++) begin
         if (b == abort_bit) begin
            hold(bits[b], N / 2);
            pulse_reset();
            return;
         end
         hold(bits[b], N);
      end
   endtask

   task automatic glitch(input int len);
      hold(1'b0, len);
      hold(1'b1, 3 * N);
   endtask

   initial begin
      n_checks      = 0;
      n_fail        = 0;
      model_data    = 8'h00;
      prev_vld      = 1'b0;
      rst_n         = 1'b1;
      bus.uart_data = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      rst_n = 1'b0;

      // Line low from reset must never start a frame.
      hold(1'b0, 100);
      check("reset_vld", int'(bus.rx_vld), 0);
      check("reset_data", int'(bus.rx_data), 0);

      hold(1'b1, 10);
      send_frame(8'h4B, 1'b1, -1);
      hold(1'b1, 10);
      check("after_4b", int'(bus.rx_data), 8'h4B);

      glitch(2);
      send_frame(8'hA5, 1'b0, -1);
      hold(1'b1, 4);
      send_frame(8'h3C, 1'b1, -1);
      hold(1'b1, 2);
      send_frame(8'h00, 1'b1, -1);
      send_frame(8'hFF, 1'b1, -1);
      hold(1'b1, 2 * N);
      send_frame(8'h99, 1'b1, 5);
      hold(1'b1, 2 * N);
      check("after_abort", int'(bus.rx_data), 0);
      send_frame(8'h55, 1'b1, -1);
      hold(1'b1, 2 * N);

      for (int i = 0; i < 150; i++) begin
         int          kind;
         logic [7:0]  d;
         kind = int'($urandom_range(0, 9));
         d    = 8'($urandom);
         case (kind)
            0: glitch(int'($urandom_range(1, 3)));
            1: begin
               send_frame(d, 1'b0, -1);
               hold(1'b1, int'($urandom_range(4, 12)));
            end
            2: begin
               send_frame(d, 1'b1, int'($urandom_range(0, 9)));
               hold(1'b1, 2 * N);
            end
            default: begin
               send_frame(d, 1'b1, -1);
               if ($urandom_range(0, 1) == 1) hold(1'b1, int'($urandom_range(1, 20)));
            end
         endcase
      end

      hold(1'b1, 20 * N);
      check("pending_expected", exp_q.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 Parameter N, default 8, clock cycles per UART bit period; legal values are even integers >= 4.
REQ-002 clk  input  1  sole clock; all state updates on the rising edge.
REQ-003 rst_n  input  1  synchronous, active-high reset, sampled on the rising clk edge; the _n suffix is the codebase port name only, not the polarity.
REQ-004 uart_data  input  1  asynchronous serial line; idle high.
REQ-005 rx_vld  output  1  one-cycle pulse marking a valid received byte.
REQ-006 rx_data  output  8  last correctly received byte.

Function
REQ-007 Frame format: 1 start bit (0), 8 data bits LSB first, 1 stop bit (1), no parity; every bit lasts N clocks.
REQ-008 uart_data passes through a 2-flop synchronizer followed by one history flop; all three flops reset to 0.
REQ-009 A start is detected only on a synchronized 1->0 transition while IDLE.
  - A line held low from reset, with no preceding high, never starts a frame.
REQ-010 States:
  - IDLE: waits for a start edge.
  - START: checks the start bit.
  - DATA: shifts in 8 data bits.
  - STOP: checks the stop bit.
  - WAIT_IDLE: recovers after a framing error.
REQ-011 A bit counter runs 0..N-1 per bit; a bit index runs 0..9; both clear on start detection.
REQ-012 Each bit is sampled once, when the bit counter equals N/2-1 (mid-bit), from the synchronized line.
REQ-013 START sample = 1 -> glitch; return to IDLE with no output change.
  - START sample = 0 -> go to DATA.
REQ-014 DATA: sample k (k = 0..7) is stored into bit k of an internal shift register.
  - After the 8th sample, go to STOP.
REQ-015 STOP sample = 1:
  - load rx_data from the shift register;
  - assert rx_vld for exactly one cycle;
  - return to IDLE.
REQ-016 STOP sample = 0 (framing error):
  - no rx_vld; rx_data unchanged;
  - go to WAIT_IDLE, which returns to IDLE once the synchronized line is 1.
REQ-017 rx_vld and rx_data are registered outputs.
  - rx_vld rises in the clock cycle immediately after the stop-bit sample.
  - rx_data takes its new value in that same cycle.
REQ-018 Latency: rx_vld asserts 9*N + N/2 + 3 clocks (+/-1) after the first clk edge that samples uart_data low at the start bit; for N=8, 79 +/- 1 clocks.
REQ-019 rx_data holds its value between frames.
  - Changes only on a valid stop bit.
REQ-020 Only the first start edge is acted on; line activity during START/DATA/STOP is ignored except at sample points.
REQ-021 Back-to-back frames: a start edge arriving in the cycle after the stop sample, or later, is accepted.

Reset
REQ-022 While rst_n = 1 at a clock edge:
  - state = IDLE;
  - counters = 0;
  - shift register = 0;
  - synchronizer flops = 0;
  - rx_vld = 0;
  - rx_data = 8'h00.
REQ-023 Reset asserted mid-frame aborts the frame: no rx_vld; rx_data returns to 8'h00.
REQ-024 After reset release, reception starts only on a subsequent 1->0 line transition.

Verification (N = 8)
REQ-025 Line low for 100 clocks after reset release -> rx_vld stays 0; rx_data = 8'h00.
REQ-026 Line high 10 clocks, then frame with bits 1,1,0,1,0,0,1,0 (D0..D7), stop = 1, 8 clocks per bit:
  - exactly one rx_vld pulse, about 79 clocks after the start falling edge;
  - rx_data = 8'h4B.
REQ-027 Idle-high line with a 2-clock low glitch -> START check fails; no rx_vld; rx_data unchanged.
REQ-028 Frame 8'hA5 with stop bit = 0 -> no rx_vld; rx_data keeps its previous value.
  - A subsequent valid 8'h3C frame after the line returns high -> rx_vld pulse, rx_data = 8'h3C.
REQ-029 Two consecutive frames 8'h00 then 8'hFF with no idle gap -> two rx_vld pulses, rx_data = 8'h00 then 8'hFF.
REQ-030 rst_n pulsed high during data bit D4 of a frame -> no rx_vld for that frame; rx_data = 8'h00.
  - A following valid 8'h55 frame -> rx_vld pulse, rx_data = 8'h55.
